// File: rtl/riscv_pkg.sv
// Shared core types: ROB tag width and the FU completion payload seen on the CDB.
package riscv_pkg;

  localparam int unsigned ReorderBufferTagWidth = 4;
  localparam int unsigned FLen                  = 64;
  localparam int unsigned ExcCauseW             = 5;
  localparam int unsigned FpFlagsW              = 5;

  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [FLen-1:0]                  value;
    logic                             exception;
    logic [ExcCauseW-1:0]             exc_cause;
    logic [FpFlagsW-1:0]              fp_flags;
  } fu_complete_t;

endpackage

// File: rtl/fu_cdb_adapter.sv
// Buffers single-cycle FU shim completions in an in-order FIFO and presents the
// head to the CDB arbiter as a request/grant client, applying pipeline flushes.
module fu_cdb_adapter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TagW  = riscv_pkg::ReorderBufferTagWidth
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  riscv_pkg::fu_complete_t  i_fu_complete,
  input  logic                     i_fu_busy,
  output logic                     o_fu_stall,
  output logic                     o_cdb_req,
  output riscv_pkg::fu_complete_t  o_cdb_data,
  input  logic                     i_cdb_grant,
  input  logic                     i_flush,
  input  logic                     i_flush_en,
  input  logic [TagW-1:0]          i_flush_tag,
  input  logic [TagW-1:0]          i_rob_head_tag,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // The stall decision lives in the RS; the busy flag is only consumed there.
  logic unused_fu_busy;
  assign unused_fu_busy = i_fu_busy;

  // Stored payload reuses the completion struct; .valid acts as the live bit.
  riscv_pkg::fu_complete_t entry_q [DEPTH];
  logic [PtrW-1:0]         rd_ptr_q;
  logic [PtrW-1:0]         wr_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    overflow_q;

  riscv_pkg::fu_complete_t head;
  logic                    not_empty;
  logic                    full;
  logic                    kill_head;
  logic                    kill_in;
  logic                    req;
  logic                    pop;
  logic                    push;
  logic                    push_ok;
  logic                    ovf_set;

  // Age relative to the ROB head, in TagW+1 bits; equal-to-boundary survives.
  function automatic logic younger(input logic [TagW-1:0] t,
                                   input logic [TagW-1:0] boundary,
                                   input logic [TagW-1:0] rob_head);
    logic [TagW:0] dt;
    logic [TagW:0] db;
    dt = {1'b0, t} - {1'b0, rob_head};
    db = {1'b0, boundary} - {1'b0, rob_head};
    return dt > db;
  endfunction

  always_comb begin
    head      = entry_q[rd_ptr_q];
    not_empty = (count_q != '0);
    full      = (count_q == CntW'(DEPTH));
    kill_head = i_flush |
                (i_flush_en & younger(TagW'(head.tag), i_flush_tag, i_rob_head_tag));
    kill_in   = i_flush |
                (i_flush_en & younger(TagW'(i_fu_complete.tag), i_flush_tag, i_rob_head_tag));
    req       = not_empty & head.valid & ~kill_head;
    // Dead heads drain one per cycle without requesting.
    pop       = (req & i_cdb_grant) | (not_empty & ~head.valid);
    push      = i_fu_complete.valid & ~kill_in;
    push_ok   = push & (~full | pop);
    ovf_set   = push & full & ~pop;
  end

  assign o_cdb_req  = req;
  assign o_cdb_data = req ? head : '0;
  assign o_fu_stall = (count_q >= CntW'(DEPTH - 1));
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | ovf_set;
      if (i_flush) begin
        for (int i = 0; i < DEPTH; i++) entry_q[i].valid <= 1'b0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i_flush_en &&
              younger(TagW'(entry_q[i].tag), i_flush_tag, i_rob_head_tag)) begin
            entry_q[i].valid <= 1'b0;
          end
        end
        if (pop) begin
          entry_q[rd_ptr_q].valid <= 1'b0;
          rd_ptr_q                <= rd_ptr_q + PtrW'(1);
        end
        // Written last so a push into the slot freed by a same-cycle pop wins.
        if (push_ok) begin
          entry_q[wr_ptr_q]       <= i_fu_complete;
          entry_q[wr_ptr_q].valid <= 1'b1;
          wr_ptr_q                <= wr_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push_ok) - CntW'(pop);
      end
    end
  end

endmodule
